// File: rtl/note_uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : note_uart_pkg
//  Description : Shared definitions for the note UART link: note width,
//                default bit timing, transmitter state encoding and the
//                parity helper used by both transmitter and decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package note_uart_pkg;

  // Width of a note code on the link.
  localparam int NOTE_W = 7;

  // 100 MHz system clock / 115200 baud.
  localparam int CLKS_PER_BIT_DEFAULT = 868;

  // Transmitter frame sequencer states, explicit 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Parity bit that makes the 8-bit data byte {P, note} even.
  function automatic logic note_parity(input logic [NOTE_W-1:0] note);
    return ^note;
  endfunction

endpackage : note_uart_pkg
`default_nettype wire

// File: rtl/note_fifo2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : note_fifo2
//  Description : Two-entry FIFO of note codes for the UART transmitter.
//                A push while full or a pop while empty is ignored.
//  Ports       : clk_in          - system clock
//                rst_in          - asynchronous reset, active low
//                push_in/data_in - write request and note to store
//                pop_in          - discard the head entry
//                data_out        - head entry (valid when not empty)
//                full_out        - two entries held
//                empty_out       - no entries held
//                count_next_out  - occupancy after the current edge
//  Revision    : 1.0 - initial release
// ============================================================================
module note_fifo2
  import note_uart_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              push_in,
  input  logic [NOTE_W-1:0] data_in,
  input  logic              pop_in,
  output logic [NOTE_W-1:0] data_out,
  output logic              full_out,
  output logic              empty_out,
  output logic [1:0]        count_next_out
);

  logic [NOTE_W-1:0] mem_q [2];
  logic [NOTE_W-1:0] mem_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              push_ok;
  logic              pop_ok;

  always_comb begin
    push_ok  = push_in && (count_q != 2'd2);
    pop_ok   = pop_in  && (count_q != 2'd0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign data_out       = mem_q[rd_ptr_q];
  assign full_out       = (count_q == 2'd2);
  assign empty_out      = (count_q == 2'd0);
  assign count_next_out = count_d;

endmodule : note_fifo2
`default_nettype wire

// File: rtl/note_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : note_uart_tx
//  Description : Buffered 8N1 UART transmitter for note codes. Each note is
//                sent LSB first as {even parity, note[6:0]} framed by a start
//                and a stop bit. Up to two notes are queued; queued frames
//                follow each other with no idle gap.
//  Ports       : clk_in         - system clock
//                rst_in         - asynchronous reset, active low
//                note_in        - note code to send
//                note_valid_in  - note_in holds a note
//                note_ready_out - a note can be accepted this cycle
//                tx_out         - serial line, idle high
//                busy_out       - frame in progress or notes queued
//  Revision    : 1.0 - initial release
// ============================================================================
module note_uart_tx
  import note_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [NOTE_W-1:0] note_in,
  input  logic              note_valid_in,
  output logic              note_ready_out,
  output logic              tx_out,
  output logic              busy_out
);

  localparam int                 C_CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(CLKS_PER_BIT - 1);

  uart_state_e        state_q, state_d;
  logic [C_CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shreg_q, shreg_d;
  logic               tx_q, tx_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;

  logic              fifo_push;
  logic              fifo_pop;
  logic [NOTE_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        fifo_count_next;
  logic              bit_done;

  // Registered ready is low through reset and tracks "fewer than two
  // entries" from the first edge after reset onward.
  assign fifo_push = note_valid_in && ready_q && !fifo_full;
  assign bit_done  = (cnt_q == C_CNT_MAX);

  note_fifo2 u_fifo (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .push_in        (fifo_push),
    .data_in        (note_in),
    .pop_in         (fifo_pop),
    .data_out       (fifo_head),
    .full_out       (fifo_full),
    .empty_out      (fifo_empty),
    .count_next_out (fifo_count_next)
  );

  // tx_d is the line value for the cycle after the edge, so every bit is
  // emitted straight from a flop and the start bit lands one edge after
  // the note is popped.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_START;
          shreg_d  = {note_parity(fifo_head), fifo_head};
          tx_d     = 1'b0;
        end
      end

      ST_START: begin
        if (bit_done) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = ST_DATA;
          tx_d    = shreg_q[0];
        end else begin
          cnt_d = cnt_q + C_CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (bit_done) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = {1'b0, shreg_q[7:1]};
            tx_d    = shreg_q[1];
          end
        end else begin
          cnt_d = cnt_q + C_CNT_W'(1);
        end
      end

      ST_STOP: begin
        if (bit_done) begin
          cnt_d = '0;
          if (!fifo_empty) begin
            // Chain straight into the next start bit.
            fifo_pop = 1'b1;
            state_d  = ST_START;
            shreg_d  = {note_parity(fifo_head), fifo_head};
            tx_d     = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + C_CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
      end
    endcase

    ready_d = (fifo_count_next != 2'd2);
    busy_d  = (state_d != ST_IDLE) || (fifo_count_next != 2'd0);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shreg_q <= 8'd0;
      tx_q    <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign note_ready_out = ready_q;
  assign tx_out         = tx_q;
  assign busy_out       = busy_q;

endmodule : note_uart_tx
`default_nettype wire

// File: tb/tb_note_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_note_uart_tx
//  Description : Directed self-checking bench for note_uart_tx with four
//                clocks per bit. Inputs change 1 ns after a rising edge and
//                outputs are sampled there, one sample per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_note_uart_tx;

  localparam int CPB = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic [6:0] note  = 7'd0;
  logic       ready;
  logic       tx;
  logic       busy;

  int errors = 0;
  int checks = 0;

  note_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk_in         (clk),
    .rst_in         (rst_n),
    .note_in        (note),
    .note_valid_in  (valid),
    .note_ready_out (ready),
    .tx_out         (tx),
    .busy_out       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame {stop, parity, note, start}, bit 0 first on the line.
  function automatic logic [9:0] frame_of(input logic [6:0] n);
    return {1'b1, ^n, n, 1'b0};
  endfunction

  function automatic logic [39:0] expand(input logic [9:0] f);
    logic [39:0] e;
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < CPB; j++)
        e[CPB*i+j] = f[i];
    return e;
  endfunction

  // Mid-bit sampling, as a receiver would do.
  function automatic logic [9:0] decode(input logic [39:0] w);
    logic [9:0] b;
    for (int i = 0; i < 10; i++) b[i] = w[CPB*i+2];
    return b;
  endfunction

  // Samples tx now and on the following n-1 clocks.
  task automatic capture(input int n, output logic [119:0] w,
                         output logic busy_and, output logic busy_or);
    w        = '1;
    busy_and = 1'b1;
    busy_or  = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      w[k]     = tx;
      busy_and = busy_and & busy;
      busy_or  = busy_or | busy;
    end
  endtask

  // Offer a note, wait (bounded) for acceptance; returns 1 ns after the
  // accepting edge with valid already dropped.
  task automatic send_note(input logic [6:0] n);
    int t;
    note  = n;
    valid = 1'b1;
    t     = 0;
    while (!ready && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("ready_wait_timeout", 128'(t < 200), 128'(1));
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [119:0] w;
    logic         b_and;
    logic         b_or;
    logic [9:0]   bits;

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", 128'(tx), 128'(1));
    check("rst_ready", 128'(ready), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    #2 rst_n = 1'b1;
    #1;
    check("ready_before_edge", 128'(ready), 128'(0));
    @(posedge clk);
    #1;
    check("ready_first_edge", 128'(ready), 128'(1));

    // ---------------- single frame, note 3C ----------------
    note  = 7'h3C;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    check("lat_tx_still_high", 128'(tx), 128'(1));
    check("lat_busy", 128'(busy), 128'(1));
    @(posedge clk);
    #1;
    capture(40, w, b_and, b_or);
    check("frame_3c", 128'(w[39:0]), 128'(expand(10'b1001111000)));
    check("frame_3c_busy", 128'(b_and), 128'(1));
    @(posedge clk);
    #1;
    check("after_3c_tx", 128'(tx), 128'(1));
    check("after_3c_busy", 128'(busy), 128'(0));

    // ---------------- three back-to-back notes ----------------
    @(posedge clk);
    #1;
    note  = 7'h10;
    valid = 1'b1;
    fork
      begin
        @(posedge clk);
        #1;
        note = 7'h11;
        @(posedge clk);
        #1;
        check("b2b_ready_after_start", 128'(ready), 128'(1));
        note = 7'h12;
        @(posedge clk);
        #1;
        check("b2b_ready_full", 128'(ready), 128'(0));
        note = 7'h55;
        for (int i = 0; i < 5; i++) begin
          @(posedge clk);
          #1;
          check("b2b_full_hold", 128'(ready), 128'(0));
        end
        valid = 1'b0;
      end
      begin
        @(posedge clk);
        @(posedge clk);
        #1;
        capture(120, w, b_and, b_or);
      end
    join
    check("b2b_frames", 128'(w),
          128'({expand(10'b1000100100), expand(10'b1000100010), expand(10'b1100100000)}));
    check("b2b_busy", 128'(b_and), 128'(1));
    @(posedge clk);
    #1;
    check("after_b2b_tx", 128'(tx), 128'(1));
    check("after_b2b_busy", 128'(busy), 128'(0));

    // ---------------- reset during data bit 3 ----------------
    note  = 7'h07;
    valid = 1'b1;
    @(posedge clk);
    #1;
    note = 7'h2A;
    @(posedge clk);
    #1;
    valid = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    check("mid_bit3_tx", 128'(tx), 128'(0));
    check("mid_bit3_busy", 128'(busy), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    check("abort_tx", 128'(tx), 128'(1));
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_ready", 128'(ready), 128'(0));
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_ready_back", 128'(ready), 128'(1));
    capture(50, w, b_and, b_or);
    check("abort_line_idle", 128'(w[49:0]), 128'({50{1'b1}}));
    check("abort_queue_flushed", 128'(b_or), 128'(0));

    // ---------------- clean frame after reset, note 01 ----------------
    send_note(7'h01);
    @(posedge clk);
    #1;
    capture(40, w, b_and, b_or);
    check("frame_01", 128'(w[39:0]), 128'(expand(10'b1100000010)));
    bits = decode(w[39:0]);
    check("frame_01_byte", 128'(bits[8:1]), 128'(8'h81));

    // ---------------- loopback of every note ----------------
    for (int n = 0; n < 128; n++) begin
      send_note(7'(n));
      @(posedge clk);
      #1;
      capture(40, w, b_and, b_or);
      check($sformatf("loop_frame_%0d", n), 128'(w[39:0]), 128'(expand(frame_of(7'(n)))));
      bits = decode(w[39:0]);
      check($sformatf("loop_note_%0d", n), 128'(bits[7:1]), 128'(n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_note_uart_tx
`default_nettype wire
